// File: rtl/round_compress_pkg.sv
// Shared constants, mode type and d-clamp helper for the Kyber-style compress/decompress pipeline.
package round_compress_pkg;

    localparam int DW     = 12;
    localparam int Q      = 3329;
    localparam int D_MAX  = 11;
    localparam int DL     = $clog2(D_MAX + 1);
    localparam int HALF_Q = (Q - 1) / 2;

    // Numerators stay below 2^NW and M*Q - 2^K < Q < 2^clog2(Q), so n*(M*Q - 2^K) < 2^K
    // and (n*M) >> K equals floor(n/Q) for every reachable numerator.
    localparam int NW = DW + D_MAX;
    localparam int K  = NW + $clog2(Q);
    localparam int PW = NW + K;
    localparam longint unsigned M = ((64'd1 << K) + 64'(Q) - 64'd1) / 64'(Q);

    typedef enum logic {
        MODE_COMPRESS   = 1'b0,
        MODE_DECOMPRESS = 1'b1
    } mode_t;

    function automatic logic [DL-1:0] clamp_d(input logic [DL-1:0] d);
        if (int'(d) > D_MAX) return DL'(D_MAX);
        return d;
    endfunction

endpackage

// File: rtl/round_compress_lane.sv
// One coefficient lane: S1 builds the numerator, S2 multiplies by the reciprocal, S3 shifts and masks.
module round_compress_lane
    import round_compress_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [DW-1:0] x,
    input  mode_t         mode0,
    input  logic [DL-1:0] d0,
    input  mode_t         mode1,
    input  mode_t         mode2,
    input  logic [DL-1:0] d2,
    output logic [DW-1:0] result
);

    logic [NW-1:0] xe;
    logic [NW-1:0] y;
    logic [NW-1:0] num0;
    logic [NW-1:0] n1;
    logic [PW-1:0] p1;
    logic [PW-1:0] p2;
    logic [PW-1:0] mask2;
    logic [PW-1:0] r2;

    // Decompress only looks at the low d bits; d = 0 leaves the numerator at zero.
    always_comb begin
        xe   = NW'(x);
        y    = xe & ((NW'(1) << d0) - NW'(1));
        num0 = '0;
        if (mode0 == MODE_COMPRESS) begin
            num0 = (xe << d0) + NW'(HALF_Q);
        end else if (d0 != '0) begin
            num0 = y * NW'(Q) + (NW'(1) << (d0 - DL'(1)));
        end
    end

    always_comb begin
        p1 = PW'(n1);
        if (mode1 == MODE_COMPRESS) p1 = PW'(n1) * PW'(M);
    end

    always_comb begin
        mask2 = (PW'(1) << d2) - PW'(1);
        r2    = p2 >> d2;
        if (mode2 == MODE_COMPRESS) r2 = (p2 >> K) & mask2;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            n1     <= '0;
            p2     <= '0;
            result <= '0;
        end else if (en) begin
            n1     <= num0;
            p2     <= p1;
            result <= DW'(r2);
        end
    end

endmodule

// File: rtl/round_compress_pipe.sv
// Multi-lane 3-stage Compress_q/Decompress_q pipeline with valid/ready on both sides.
// Defining ROUND_COMPRESS_BEAT_CNT_EN adds a saturating output-transfer counter on beat_cnt.
module round_compress_pipe
    import round_compress_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_mode,
    input  logic [DL-1:0]       in_d,
    input  logic [LANES*DW-1:0] in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_mode,
    output logic [DL-1:0]       out_d,
    output logic [LANES*DW-1:0] out_data,
    output logic                err
`ifdef ROUND_COMPRESS_BEAT_CNT_EN
    ,
    output logic [31:0]         beat_cnt
`endif
);

    // valid/ready: a beat moves when valid and ready are both high in the same cycle; the whole
    // pipe shifts together whenever the output slot is empty or being drained.
    logic          advance;
    logic          s1_valid, s2_valid, s3_valid;
    mode_t         mode0, s1_mode, s2_mode, s3_mode;
    logic [DL-1:0] d0, s1_d, s2_d, s3_d;

    assign advance   = out_ready | ~s3_valid;
    assign in_ready  = advance;
    assign mode0     = mode_t'(in_mode);
    assign d0        = clamp_d(in_d);
    assign out_valid = s3_valid;
    assign out_mode  = s3_mode;
    assign out_d     = s3_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s3_valid <= 1'b0;
            s1_mode  <= MODE_COMPRESS;
            s2_mode  <= MODE_COMPRESS;
            s3_mode  <= MODE_COMPRESS;
            s1_d     <= '0;
            s2_d     <= '0;
            s3_d     <= '0;
            err      <= 1'b0;
        end else begin
            if (in_valid && advance && int'(in_d) > D_MAX) err <= 1'b1;
            if (advance) begin
                s1_valid <= in_valid;
                s2_valid <= s1_valid;
                s3_valid <= s2_valid;
                s1_mode  <= mode0;
                s2_mode  <= s1_mode;
                s3_mode  <= s2_mode;
                s1_d     <= d0;
                s2_d     <= s1_d;
                s3_d     <= s2_d;
            end
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        round_compress_lane u_lane (
            .clk    (clk),
            .rst_n  (rst_n),
            .en     (advance),
            .x      (in_data[i*DW +: DW]),
            .mode0  (mode0),
            .d0     (d0),
            .mode1  (s1_mode),
            .mode2  (s2_mode),
            .d2     (s2_d),
            .result (out_data[i*DW +: DW])
        );
    end

`ifdef ROUND_COMPRESS_BEAT_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            beat_cnt <= '0;
        end else if (out_valid && out_ready && beat_cnt != '1) begin
            beat_cnt <= beat_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_round_compress_pipe.sv
// Directed and randomized bench for round_compress_pipe with a division-based reference model.
module tb_round_compress_pipe;
    import round_compress_pkg::*;

    localparam int LANES  = 4;
    localparam int BW     = LANES * DW;
    localparam int W      = 1 + DL + BW;
    localparam int REF_Q  = 3329;
    localparam int REF_DM = 11;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic          in_mode;
    logic [DL-1:0] in_d;
    logic [BW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_mode;
    logic [DL-1:0] out_d;
    logic [BW-1:0] out_data;
    logic          err;
`ifdef ROUND_COMPRESS_BEAT_CNT_EN
    logic [31:0]   beat_cnt;
`endif

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];
    int n_out = 0;
    int n_stall = 0;
    int n_xfer = 0;
    logic accepted = 1'b0;
    logic rand_ready = 1'b0;
    logic hold_pend = 1'b0;
    logic [W-1:0] held = '0;

    round_compress_pipe #(.LANES(LANES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_d      (in_d),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_mode  (out_mode),
        .out_d     (out_d),
        .out_data  (out_data),
        .err       (err)
`ifdef ROUND_COMPRESS_BEAT_CNT_EN
        ,
        .beat_cnt  (beat_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // Reference: exact rational rounding with integer division.
    function automatic logic [DW-1:0] ref_lane(input logic mode, input int d, input int x);
        longint span;
        longint num;
        if (d == 0) return '0;
        span = longint'(1) << d;
        if (!mode) begin
            num = (longint'(x) * span + (REF_Q - 1) / 2) / REF_Q;
            return DW'(num % span);
        end
        num = ((longint'(x) % span) * REF_Q + span / 2) / span;
        return DW'(num);
    endfunction

    function automatic logic [W-1:0] ref_beat(input logic mode, input int d, input logic [BW-1:0] data);
        logic [BW-1:0] res;
        int de;
        de = (d > REF_DM) ? REF_DM : d;
        for (int i = 0; i < LANES; i++) res[i*DW +: DW] = ref_lane(mode, de, int'(data[i*DW +: DW]));
        return {mode, DL'(de), res};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample handshakes at the falling edge, then step past the rising edge.
    task automatic cycle();
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        accepted = rst_n && in_valid && in_ready;
        if (rst_n) begin
            if (hold_pend) chk("hold_stable", {out_mode, out_d, out_data}, held);
            hold_pend = out_valid && !out_ready;
            held = {out_mode, out_d, out_data};
            if (accepted) exp_q.push_back(ref_beat(in_mode, int'(in_d), in_data));
            if (in_valid && !in_ready) n_stall++;
            if (out_valid && out_ready) begin
                n_out++;
                n_xfer++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $error("FAIL spurious_beat observed=%0h expected=none", {out_mode, out_d, out_data});
                end else begin
                    chk("beat", {out_mode, out_d, out_data}, exp_q.pop_front());
                end
            end
        end
        @(posedge clk);
        #1;
        if (!rst_n) begin
            exp_q.delete();
            hold_pend = 1'b0;
            n_xfer = 0;
        end
    endtask

    task automatic send(input logic mode, input int d, input logic [BW-1:0] data);
        int g;
        g = 0;
        in_valid = 1'b1;
        in_mode  = mode;
        in_d     = DL'(d);
        in_data  = data;
        do begin
            cycle();
            g++;
        end while (!accepted && g < 50);
        in_valid = 1'b0;
        chk("send_accepted", accepted, 1);
    endtask

    task automatic wait_out();
        int g;
        g = 0;
        while (!out_valid && g < 20) begin
            cycle();
            g++;
        end
        chk("wait_out_valid", out_valid, 1);
    endtask

    task automatic drain();
        int g;
        g = 0;
        while ((exp_q.size() != 0 || out_valid) && g < 200) begin
            cycle();
            g++;
        end
        chk("drain_empty", exp_q.size(), 0);
    endtask

    function automatic logic [BW-1:0] splat(input int x);
        logic [BW-1:0] v;
        for (int i = 0; i < LANES; i++) v[i*DW +: DW] = DW'(x);
        return v;
    endfunction

    function automatic logic [BW-1:0] rand_data();
        logic [BW-1:0] v;
        for (int i = 0; i < LANES; i++) v[i*DW +: DW] = DW'($urandom_range(0, (1 << DW) - 1));
        return v;
    endfunction

    task automatic one(input string tag, input logic mode, input int d, input int x, input int exp);
        send(mode, d, splat(x));
        wait_out();
        chk(tag, out_data[DW-1:0], exp);
        cycle();
    endtask

    initial begin
        logic [BW-1:0] bp_data;
        int sent;
        logic saw_drop;

        rst_n = 1'b0; in_valid = 1'b0; in_mode = 1'b0; in_d = '0; in_data = '0; out_ready = 1'b1;
        repeat (2) cycle();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_err", err, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_mode", out_mode, 0);
        chk("rst_out_d", out_d, 0);
`ifdef ROUND_COMPRESS_BEAT_CNT_EN
        chk("rst_beat_cnt", beat_cnt, 0);
`endif
        rst_n = 1'b1;
        cycle();

        // Compress d=1 on {832,833,2497,3328}; output appears in the third cycle after acceptance.
        in_valid = 1'b1; in_mode = 1'b0; in_d = DL'(1);
        in_data = {12'd3328, 12'd2497, 12'd833, 12'd832};
        cycle();
        chk("lat_accept", accepted, 1);
        in_valid = 1'b0;
        chk("lat_edge1", out_valid, 0);
        cycle();
        chk("lat_edge2", out_valid, 0);
        cycle();
        chk("lat_edge3", out_valid, 1);
        chk("d1_data", out_data, {12'd0, 12'd0, 12'd1, 12'd0});
        cycle();

        one("c_d10_3328", 1'b0, 10, 3328, 0);
        one("dc_d10_1023", 1'b1, 10, 1023, 3326);
        one("dc_d1_1", 1'b1, 1, 1, 1665);
        one("c_d0", 1'b0, 0, 2000, 0);
        one("dc_d0", 1'b1, 0, 4095, 0);
        one("dc_upper_ignored", 1'b1, 4, 4089, 1873);

        // Exhaustive compress sweep, back-to-back.
        n_out = 0; n_stall = 0;
        for (int d = 1; d <= REF_DM; d++) begin
            for (int b = 0; b < 1024; b++) begin
                in_valid = 1'b1; in_mode = 1'b0; in_d = DL'(d);
                for (int l = 0; l < LANES; l++) in_data[l*DW +: DW] = DW'(b * LANES + l);
                cycle();
            end
        end
        in_valid = 1'b0;
        repeat (3) cycle();
        chk("sweep_beats", n_out, 11 * 1024);
        chk("sweep_stalls", n_stall, 0);
        chk("sweep_queue", exp_q.size(), 0);

        // Backpressure: 5 beats, out_ready low for 6 cycles.
        out_ready = 1'b0; n_out = 0; sent = 0; saw_drop = 1'b0;
        bp_data = rand_data();
        for (int c = 0; c < 6; c++) begin
            in_valid = (sent < 5); in_mode = 1'($urandom_range(0, 1));
            in_d = DL'($urandom_range(1, REF_DM)); in_data = bp_data;
            cycle();
            if (accepted) begin
                sent++;
                bp_data = rand_data();
            end
            if (!in_ready) saw_drop = 1'b1;
        end
        chk("bp_in_ready_drop", saw_drop, 1);
        chk("bp_no_output", n_out, 0);
        chk("bp_accepted_full", sent, 3);
        out_ready = 1'b1;
        while (sent < 5) begin
            send(1'($urandom_range(0, 1)), $urandom_range(1, REF_DM), rand_data());
            sent++;
        end
        drain();
        chk("bp_beats_out", n_out, 5);

        // Illegal d clamps to D_MAX and sets the sticky error.
        send(1'b0, 12, splat(3328));
        chk("err_rise", err, 1);
        wait_out();
        chk("illegal_out_d", out_d, 11);
        chk("illegal_lane0", out_data[DW-1:0], 2047);
        chk("illegal_lane3", out_data[BW-1 -: DW], 2047);
        cycle();
        one("legal_after_illegal", 1'b1, 4, 9, 1873);
        chk("err_sticky", err, 1);

        // Randomized mixed traffic with random backpressure.
        rand_ready = 1'b1;
        for (int i = 0; i < 400; i++) send(1'($urandom_range(0, 1)), $urandom_range(0, 15), rand_data());
        rand_ready = 1'b0; out_ready = 1'b1;
        drain();
        chk("err_after_random", err, 1);

        // Reset with three beats in flight.
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_mode = 1'b0; in_d = DL'(5); in_data = rand_data();
            cycle();
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_err", err, 0);
        chk("midrst_in_ready", in_ready, 1);
`ifdef ROUND_COMPRESS_BEAT_CNT_EN
        chk("midrst_beat_cnt", beat_cnt, 0);
`endif
        n_out = 0;
        repeat (6) cycle();
        chk("midrst_no_stale", n_out, 0);
        for (int i = 0; i < 4; i++) send(1'($urandom_range(0, 1)), $urandom_range(1, REF_DM), rand_data());
        drain();
        chk("post_rst_beats", n_out, 4);
`ifdef ROUND_COMPRESS_BEAT_CNT_EN
        chk("beat_cnt", beat_cnt, 64'(n_xfer));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
